// File: rtl/sensor_adc_sequencer.sv
// Measurement sequencer: powers the sensor/ADC, waits a settle time, strobes
// 2^NUM_SAMPLES_LOG2 conversions and returns their truncated average.
module sensor_adc_sequencer #(
  parameter int ADC_WIDTH        = 16,
  parameter int NUM_SAMPLES_LOG2 = 2,
  parameter int SETTLE_TICKS     = 64,
  parameter int TIMEOUT_TICKS    = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2:0]           config_in,
  output logic                 busy,
  output logic                 done,
  output logic [ADC_WIDTH-1:0] result,
  output logic                 timeout_err,
  output logic [2:0]           sens_config,
  output logic                 sens_enable,
  output logic                 sens_read,
  output logic                 adc_enable,
  output logic                 adc_read,
  input  logic                 adc_conversion_complete,
  input  logic [ADC_WIDTH-1:0] adc_value
);

  localparam int SW  = (NUM_SAMPLES_LOG2 > 0) ? NUM_SAMPLES_LOG2 : 1;
  localparam int AW  = ADC_WIDTH + NUM_SAMPLES_LOG2;
  localparam int STW = $clog2(SETTLE_TICKS + 1);
  localparam int TW  = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [SW-1:0]  LAST_SAMPLE  = SW'((1 << NUM_SAMPLES_LOG2) - 1);
  localparam logic [STW-1:0] SETTLE_LOAD  = STW'(SETTLE_TICKS - 1);
  localparam logic [TW-1:0]  TIMEOUT_LOAD = TW'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, CONVERT, WAIT, DONE} state_t;

  state_t state, state_next;

  logic [STW-1:0]       settle_cnt, settle_cnt_d;
  logic [TW-1:0]        tmo_cnt, tmo_cnt_d;
  logic [SW-1:0]        samp_cnt, samp_cnt_d;
  logic [AW-1:0]        acc, acc_d, acc_sum;
  logic [ADC_WIDTH-1:0] result_d;
  logic                 timeout_err_d;
  logic [2:0]           sens_config_d;
  logic                 busy_d, done_d, enable_d, read_d;

  assign acc_sum = acc + AW'(adc_value);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Abort outranks everything once a sequence is running; in IDLE it only masks start.
  always_comb begin
    state_next = state;
    if (state != IDLE && abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start && !abort) state_next = SETTLE;
        SETTLE:  if (settle_cnt == '0) state_next = CONVERT;
        CONVERT: state_next = WAIT;
        WAIT: begin
          if (adc_conversion_complete)
            state_next = (samp_cnt == LAST_SAMPLE) ? DONE : CONVERT;
          else if (tmo_cnt == TW'(1))
            state_next = DONE;
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output values are derived from the next state so every output leaves a flop.
  always_comb begin
    settle_cnt_d  = settle_cnt;
    tmo_cnt_d     = tmo_cnt;
    samp_cnt_d    = samp_cnt;
    acc_d         = acc;
    result_d      = result;
    timeout_err_d = timeout_err;
    sens_config_d = sens_config;
    busy_d        = (state_next != IDLE);
    done_d        = (state_next == DONE);
    enable_d      = (state_next != IDLE);
    read_d        = (state_next == CONVERT);
    case (state)
      IDLE: begin
        if (state_next == SETTLE) begin
          sens_config_d = config_in;
          acc_d         = '0;
          samp_cnt_d    = '0;
          timeout_err_d = 1'b0;
          settle_cnt_d  = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (settle_cnt != '0) settle_cnt_d = settle_cnt - STW'(1);
      end
      CONVERT: tmo_cnt_d = TIMEOUT_LOAD;
      WAIT: begin
        if (!abort) begin
          if (adc_conversion_complete) begin
            acc_d = acc_sum;
            if (samp_cnt == LAST_SAMPLE)
              result_d = ADC_WIDTH'(acc_sum >> NUM_SAMPLES_LOG2);
            else
              samp_cnt_d = samp_cnt + SW'(1);
          end else if (tmo_cnt == TW'(1)) begin
            timeout_err_d = 1'b1;
            result_d      = '0;
            tmo_cnt_d     = '0;
          end else begin
            tmo_cnt_d = tmo_cnt - TW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt  <= '0;
      tmo_cnt     <= '0;
      samp_cnt    <= '0;
      acc         <= '0;
      result      <= '0;
      timeout_err <= 1'b0;
      sens_config <= 3'b000;
      busy        <= 1'b0;
      done        <= 1'b0;
      sens_enable <= 1'b0;
      adc_enable  <= 1'b0;
      sens_read   <= 1'b0;
      adc_read    <= 1'b0;
    end else begin
      settle_cnt  <= settle_cnt_d;
      tmo_cnt     <= tmo_cnt_d;
      samp_cnt    <= samp_cnt_d;
      acc         <= acc_d;
      result      <= result_d;
      timeout_err <= timeout_err_d;
      sens_config <= sens_config_d;
      busy        <= busy_d;
      done        <= done_d;
      sens_enable <= enable_d;
      adc_enable  <= enable_d;
      sens_read   <= read_d;
      adc_read    <= read_d;
    end
  end

endmodule

// File: doc/sensor_adc_sequencer.md
Name: sensor_adc_sequencer

Overview:
Sits between the 14443-4 adapter and the analogue sensor/ADC pins. It converts a single-cycle measurement request into a timed sequence: enable sensor and ADC, wait a settle time, issue read strobes, and collect 2^NUM_SAMPLES_LOG2 conversions. It then returns the truncated average with a done pulse. Per-conversion timeout and abort (for example on a new PCD frame) stop the block hanging on a dead ADC.

Parameters:
ADC_WIDTH, 16, width of adc_value and result
NUM_SAMPLES_LOG2, 2, log2 of conversions averaged per request (0..4)
SETTLE_TICKS, 64, cycles between enable assertion and first read strobe (>=1)
TIMEOUT_TICKS, 4096, max cycles waiting for adc_conversion_complete per conversion (>=2)

Ports:
clk  in  1  13.56MHz system clock
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle request; sampled only in IDLE
abort  in  1  cancel sequence; priority over all other inputs except rst
config_in  in  3  sensor configuration, captured on accepted start
busy  out  1  high from the cycle after an accepted start until DONE inclusive
done  out  1  one-cycle pulse when result/timeout_err are valid
result  out  ADC_WIDTH  averaged value; held until the next accepted start
timeout_err  out  1  set with done if any conversion timed out; held like result
sens_config  out  3  registered copy of config_in
sens_enable  out  1  sensor power enable
sens_read  out  1  sensor read strobe
adc_enable  out  1  ADC enable
adc_read  out  1  ADC conversion start strobe
adc_conversion_complete  in  1  ADC conversion finished (already registered upstream)
adc_value  in  ADC_WIDTH  conversion result, valid when complete=1

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE. All outputs are 0, including result, timeout_err and sens_config. Counters and accumulator are 0. Reset mid-sequence aborts immediately, with no done.
- All outputs are registered.
- FSM states: IDLE, SETTLE, CONVERT, WAIT, DONE.
- IDLE:
  - start=1 and abort=0 at edge N: capture config_in into sens_config; clear accumulator, sample counter and timeout_err; load settle counter with SETTLE_TICKS-1.
  - From cycle N+1: state=SETTLE, busy=1, sens_enable=1, adc_enable=1.
- SETTLE: decrement each cycle; at 0 go to CONVERT. SETTLE therefore lasts exactly SETTLE_TICKS cycles.
- CONVERT: exactly one cycle with sens_read=1 and adc_read=1. Load timeout counter with TIMEOUT_TICKS-1, then go to WAIT.
- WAIT: adc_conversion_complete is honoured only in WAIT; a complete coinciding with CONVERT is ignored. On complete=1:
  - accumulator += zero-extended adc_value;
  - if sample counter == 2^NUM_SAMPLES_LOG2-1, go to DONE; else increment sample counter and go to CONVERT next cycle (no re-settle).
- Timeout: if the timeout counter reaches 0 with complete=0, set timeout_err=1 and go to DONE. Remaining samples are skipped and result=0.
- Accumulator width: ADC_WIDTH+NUM_SAMPLES_LOG2 (no overflow possible). result = accumulator >> NUM_SAMPLES_LOG2 (truncating).
- DONE: one cycle.
  - done=1 and busy=1; result and timeout_err valid this cycle and held afterwards.
  - sens_enable and adc_enable drop to 0 the cycle after DONE, when the state returns to IDLE.
- Latency, single sample, no timeout: start at edge N, first read strobe in cycle N+1+SETTLE_TICKS. If complete arrives k cycles after the strobe, done occurs in cycle N+SETTLE_TICKS+k+2.
- abort=1 in any non-IDLE state:
  - next cycle state=IDLE and all enables/strobes/busy=0;
  - no done pulse; result, timeout_err and sens_config keep their previous values.
  - abort in IDLE has no effect.
- start while busy: ignored, with no queueing. start and abort together in IDLE: abort wins, so start is ignored.
- sens_read and adc_read are never high for more than one consecutive cycle, and never outside CONVERT.

Test Plan:
- Single sample (NUM_SAMPLES_LOG2=0, SETTLE_TICKS=4), config_in=3'b101, start at cycle 0:
  - sens_config=5 from cycle 1; enables high from cycle 1; read strobes only in cycle 5;
  - complete with adc_value=16'h1234 in cycle 8 -> done in cycle 9, result=16'h1234, timeout_err=0;
  - enables low from cycle 10.
- Averaging (log2=2), ADC returns 100, 101, 102, 103:
  - exactly 4 read strobes, one per conversion, each followed by a WAIT; result=101 (406>>2).
- Overflow bound (log2=4), all samples 16'hFFFF -> result=16'hFFFF. All samples 16'h0001 except one 16'h0000 -> result=0 (15>>4).
- Timeout (TIMEOUT_TICKS=8), complete never asserted:
  - done exactly 8 cycles after the strobe cycle, timeout_err=1, result=0;
  - a later successful run clears timeout_err.
- Abort in WAIT: no done; enables/busy low the next cycle; result retains the previous value (e.g. 101). A complete arriving after the abort is ignored.
- Busy/reset interplay:
  - start pulsed during SETTLE -> no restart and settle length unchanged;
  - rst asserted in WAIT -> all outputs 0 the next cycle, no done.
